tournament_predictor_gshare: RTL and testbench



---
 rtl/tournament_predictor_gshare_if.sv | 36 +++
 rtl/tournament_predictor_gshare.sv | 84 ++++++++
 tb/tb_tournament_predictor_gshare.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tournament_predictor_gshare_if.sv
// Fetch-lookup and execute-resolution bundle for the tournament predictor.
// The fetch/execute side drives as master; the predictor is the slave.
interface tournament_predictor_gshare_if #(
  parameter int IDX_BITS = 10,
  parameter int GHR_BITS = 8
);
  logic                pred_valid;
  logic [IDX_BITS-1:0] pred_idx;
  logic                pred_taken;
  logic                pred_use_global;
  logic                pred_local_taken;
  logic                pred_global_taken;
  logic [GHR_BITS-1:0] pred_ghr;

  logic                upd_valid;
  logic [IDX_BITS-1:0] upd_idx;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_taken;
  logic                upd_local_taken;
  logic                upd_global_taken;
  logic                upd_mispredict;

  modport master (
    output pred_valid, pred_idx,
    output upd_valid, upd_idx, upd_ghr, upd_taken, upd_local_taken,
           upd_global_taken, upd_mispredict,
    input  pred_taken, pred_use_global, pred_local_taken, pred_global_taken, pred_ghr
  );

  modport slave (
    input  pred_valid, pred_idx,
    input  upd_valid, upd_idx, upd_ghr, upd_taken, upd_local_taken,
           upd_global_taken, upd_mispredict,
    output pred_taken, pred_use_global, pred_local_taken, pred_global_taken, pred_ghr
  );
endinterface

// File: rtl/tournament_predictor_gshare.sv
// Tournament branch predictor: per-PC local counters, gshare global table and a
// per-PC meta chooser; combinational lookup, resolution-time training and GHR repair.
module tournament_predictor_gshare #(
  parameter int IDX_BITS  = 10,
  parameter int GHR_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int META_BITS = 2
) (
  input logic clk,
  input logic rst,
  tournament_predictor_gshare_if.slave bp
);
  localparam int ENTRIES = 2**IDX_BITS;
  localparam logic [CTR_BITS-1:0]  CTR_INIT  = CTR_BITS'(2**(CTR_BITS-1)-1);
  localparam logic [META_BITS-1:0] META_INIT = META_BITS'(2**(META_BITS-1)-1);
  localparam logic [CTR_BITS-1:0]  CTR_MAX   = '1;
  localparam logic [META_BITS-1:0] META_MAX  = '1;

  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    else    return (c == '0)      ? c : c - CTR_BITS'(1);
  endfunction

  function automatic logic [META_BITS-1:0] meta_step(input logic [META_BITS-1:0] c, input logic up);
    if (up) return (c == META_MAX) ? c : c + META_BITS'(1);
    else    return (c == '0)       ? c : c - META_BITS'(1);
  endfunction

  logic [CTR_BITS-1:0]  loc_tbl  [ENTRIES];
  logic [CTR_BITS-1:0]  glb_tbl  [ENTRIES];
  logic [META_BITS-1:0] meta_tbl [ENTRIES];
  logic [GHR_BITS-1:0]  ghr, ghr_shift, ghr_recover;
  logic [IDX_BITS-1:0]  pred_gidx, upd_gidx;
  logic                 glb_ok, loc_ok;

  assign pred_gidx = bp.pred_idx ^ IDX_BITS'(ghr);
  assign upd_gidx  = bp.upd_idx  ^ IDX_BITS'(bp.upd_ghr);

  // Reads are asynchronous so a same-cycle update is seen only the next cycle.
  assign bp.pred_local_taken  = loc_tbl[bp.pred_idx][CTR_BITS-1];
  assign bp.pred_global_taken = glb_tbl[pred_gidx][CTR_BITS-1];
  assign bp.pred_use_global   = meta_tbl[bp.pred_idx][META_BITS-1];
  assign bp.pred_taken        = bp.pred_use_global ? bp.pred_global_taken : bp.pred_local_taken;
  assign bp.pred_ghr          = ghr;

  if (GHR_BITS == 1) begin : g_ghr1
    assign ghr_shift   = bp.pred_taken;
    assign ghr_recover = bp.upd_taken;
  end else begin : g_ghrn
    assign ghr_shift   = {ghr[GHR_BITS-2:0], bp.pred_taken};
    assign ghr_recover = {bp.upd_ghr[GHR_BITS-2:0], bp.upd_taken};
  end

  // Recovery wins over the speculative shift; that prediction is squashed upstream.
  always_ff @(posedge clk) begin
    if (rst)                                ghr <= '0;
    else if (bp.upd_valid && bp.upd_mispredict) ghr <= ghr_recover;
    else if (bp.pred_valid)                 ghr <= ghr_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        loc_tbl[i] <= CTR_INIT;
        glb_tbl[i] <= CTR_INIT;
      end
    end else if (bp.upd_valid) begin
      loc_tbl[bp.upd_idx] <= ctr_step(loc_tbl[bp.upd_idx], bp.upd_taken);
      glb_tbl[upd_gidx]   <= ctr_step(glb_tbl[upd_gidx], bp.upd_taken);
    end
  end

  // Chooser only moves when exactly one component was right.
  assign glb_ok = (bp.upd_global_taken == bp.upd_taken);
  assign loc_ok = (bp.upd_local_taken  == bp.upd_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) meta_tbl[i] <= META_INIT;
    end else if (bp.upd_valid && (glb_ok != loc_ok)) begin
      meta_tbl[bp.upd_idx] <= meta_step(meta_tbl[bp.upd_idx], glb_ok);
    end
  end
endmodule

// File: tb/tb_tournament_predictor_gshare.sv
// Directed bench for tournament_predictor_gshare with hand-computed expectations.
module tb_tournament_predictor_gshare;
  localparam int IDX_BITS = 10;
  localparam int GHR_BITS = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tournament_predictor_gshare_if #(.IDX_BITS(IDX_BITS), .GHR_BITS(GHR_BITS)) bp ();

  tournament_predictor_gshare #(
    .IDX_BITS(IDX_BITS), .GHR_BITS(GHR_BITS), .CTR_BITS(2), .META_BITS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [9:0] idx, input logic [7:0] g, input logic tk,
                     input logic lt, input logic gt, input logic mp);
    bp.upd_valid        = 1'b1;
    bp.upd_idx          = idx;
    bp.upd_ghr          = g;
    bp.upd_taken        = tk;
    bp.upd_local_taken  = lt;
    bp.upd_global_taken = gt;
    bp.upd_mispredict   = mp;
    tick();
    bp.upd_valid      = 1'b0;
    bp.upd_mispredict = 1'b0;
  endtask

  task automatic look(input logic [9:0] idx);
    bp.pred_idx = idx;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bp.pred_valid = 1'b0; bp.pred_idx = '0;
    bp.upd_valid = 1'b0; bp.upd_idx = '0; bp.upd_ghr = '0; bp.upd_taken = 1'b0;
    bp.upd_local_taken = 1'b0; bp.upd_global_taken = 1'b0; bp.upd_mispredict = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    look(10'h005);
    chk("rst_taken",  bp.pred_taken, 0);
    chk("rst_useg",   bp.pred_use_global, 0);
    chk("rst_ghr",    bp.pred_ghr, 0);
    chk("rst_local",  bp.pred_local_taken, 0);
    chk("rst_global", bp.pred_global_taken, 0);

    // train idx 5 taken: 1->2 then saturate at 3
    upd(10'h005, 8'h00, 1, 0, 0, 0);
    look(10'h005);
    chk("tr1_local",  bp.pred_local_taken, 1);
    chk("tr1_global", bp.pred_global_taken, 1);
    chk("tr1_useg",   bp.pred_use_global, 0);
    upd(10'h005, 8'h00, 1, 0, 0, 0);
    upd(10'h005, 8'h00, 1, 0, 0, 0);
    upd(10'h005, 8'h00, 1, 0, 0, 0);
    look(10'h005);
    chk("tr4_taken", bp.pred_taken, 1);
    chk("tr4_ghr",   bp.pred_ghr, 0);
    // one decrement from saturated 3 leaves 2 (still taken)
    upd(10'h005, 8'h00, 0, 0, 0, 0);
    look(10'h005);
    chk("sat_dec_local",  bp.pred_local_taken, 1);
    chk("sat_dec_global", bp.pred_global_taken, 1);

    // speculative history: three taken predictions at idx 5
    bp.pred_valid = 1'b1;
    chk("spec_ghr0", bp.pred_ghr, 8'h00);
    tick(); chk("spec_ghr1", bp.pred_ghr, 8'h01);
    tick(); chk("spec_ghr2", bp.pred_ghr, 8'h03);
    tick(); chk("spec_ghr3", bp.pred_ghr, 8'h07);
    // recovery in the same cycle as a prediction; shift is dropped
    upd(10'h300, 8'h01, 0, 0, 0, 1);
    bp.pred_valid = 1'b0;
    chk("recover_ghr", bp.pred_ghr, 8'h02);
    upd(10'h300, 8'h00, 0, 0, 0, 1);
    chk("recover_ghr0", bp.pred_ghr, 8'h00);
    // a correct resolution does not touch the GHR
    upd(10'h300, 8'h55, 0, 0, 0, 0);
    chk("noreco_ghr", bp.pred_ghr, 8'h00);

    // meta training at 0x010
    upd(10'h010, 8'h00, 1, 0, 1, 0);
    look(10'h010);
    chk("meta_inc1", bp.pred_use_global, 1);
    upd(10'h010, 8'h00, 1, 0, 1, 0);
    upd(10'h010, 8'h00, 1, 1, 0, 0);
    look(10'h010);
    chk("meta_dec1", bp.pred_use_global, 1);
    // steer gidx to an untrained global entry: global chosen, says not-taken
    upd(10'h200, 8'h00, 1, 0, 0, 1);
    look(10'h010);
    chk("mux_ghr",    bp.pred_ghr, 8'h01);
    chk("mux_local",  bp.pred_local_taken, 1);
    chk("mux_global", bp.pred_global_taken, 0);
    chk("mux_taken",  bp.pred_taken, 0);
    upd(10'h200, 8'h00, 0, 0, 0, 1);
    chk("mux_ghr_back", bp.pred_ghr, 8'h00);
    upd(10'h010, 8'h00, 1, 1, 1, 0);
    look(10'h010);
    chk("meta_both_ok", bp.pred_use_global, 1);
    chk("meta_g_taken", bp.pred_taken, 1);
    upd(10'h010, 8'h00, 1, 1, 0, 0);
    look(10'h010);
    chk("meta_dec2", bp.pred_use_global, 0);

    // same-cycle predict and update: read-before-write
    bp.pred_idx = 10'h020;
    bp.upd_valid = 1'b1; bp.upd_idx = 10'h020; bp.upd_ghr = 8'h00; bp.upd_taken = 1'b1;
    bp.upd_local_taken = 1'b0; bp.upd_global_taken = 1'b0; bp.upd_mispredict = 1'b0;
    #1;
    chk("rbw_same", bp.pred_taken, 0);
    tick();
    bp.upd_valid = 1'b0;
    #1;
    chk("rbw_next", bp.pred_taken, 1);

    // mid-stream reset; inputs in the reset cycle are ignored
    rst = 1'b1;
    bp.pred_valid = 1'b1;
    bp.upd_valid = 1'b1; bp.upd_idx = 10'h020; bp.upd_taken = 1'b1;
    bp.upd_ghr = 8'h3c; bp.upd_mispredict = 1'b1;
    tick();
    rst = 1'b0;
    bp.pred_valid = 1'b0; bp.upd_valid = 1'b0; bp.upd_mispredict = 1'b0;
    look(10'h005);
    chk("mrst_ghr",     bp.pred_ghr, 0);
    chk("mrst_t005",    bp.pred_taken, 0);
    chk("mrst_g005",    bp.pred_global_taken, 0);
    look(10'h010);
    chk("mrst_t010",    bp.pred_taken, 0);
    chk("mrst_useg010", bp.pred_use_global, 0);
    look(10'h020);
    chk("mrst_t020",    bp.pred_taken, 0);
    look(10'h200);
    chk("mrst_t200",    bp.pred_taken, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
